fpu_issue_ctrl: RTL



---
 rtl/fpu_pkg.sv | 43 ++++
 rtl/fpu_issue_ctrl.sv | 115 +++++++++++
 2 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU issue definitions: funct7 codes, op encodings, FSM states
// and the funct7 decode helper.
package fpu_pkg;

    localparam logic [6:0] F7_FADD = 7'b0000000;
    localparam logic [6:0] F7_FSUB = 7'b0000100;
    localparam logic [6:0] F7_FMUL = 7'b0001000;
    localparam logic [6:0] F7_FDIV = 7'b0001100;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } fpu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        WB   = 2'b10
    } fpu_state_e;

    typedef struct packed {
        fpu_op_e op;
        logic    legal;
    } fpu_dec_t;

    // funct7 -> {op, legal}; unsupported codes decode as illegal add
    function automatic fpu_dec_t decode_f7(input logic [6:0] f7);
        fpu_dec_t d;
        d.op    = OP_ADD;
        d.legal = 1'b1;
        unique case (f7)
            F7_FADD: d.op = OP_ADD;
            F7_FSUB: d.op = OP_SUB;
            F7_FMUL: d.op = OP_MUL;
            F7_FDIV: d.op = OP_DIV;
            default: d.legal = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/fpu_issue_ctrl.sv
// Issue/sequencing controller for the multi-cycle single-precision FPU:
// accepts one FP op at a time, counts out its latency, strobes writeback,
// and stalls decode on structural and RAW hazards.
module fpu_issue_ctrl
    import fpu_pkg::*;
#(
    parameter int unsigned ADD_LAT = 3,
    parameter int unsigned MUL_LAT = 4,
    parameter int unsigned DIV_LAT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       fpu_en,
    input  logic [6:0] func_7,
    input  logic [4:0] fd,
    input  logic [4:0] fs1,
    input  logic [4:0] fs2,
    input  logic       read_regport_f1,
    input  logic       read_regport_f2,
    input  logic       flush,
    output logic       stall,
    output logic       fpu_start,
    output logic [1:0] fpu_op,
    output logic       wb_enable_f,
    output logic [4:0] wb_rd_f,
    output logic       illegal_op,
    output logic       busy
);

    fpu_state_e state, state_nxt;
    fpu_op_e    op_q;
    logic [4:0] cnt;
    logic [4:0] pend_rd;
    logic       start_q;
    logic       illegal_q;

    fpu_dec_t   dec;
    logic       raw_hazard;
    logic       accept;
    logic       illegal_req;

    // Execute-cycle count minus one, loaded into cnt on accept
    function automatic logic [4:0] cnt_init(input fpu_op_e op);
        logic [4:0] v;
        unique case (op)
            OP_MUL:  v = 5'(MUL_LAT - 1);
            OP_DIV:  v = 5'(DIV_LAT - 1);
            default: v = 5'(ADD_LAT - 1);
        endcase
        return v;
    endfunction

    assign dec = decode_f7(func_7);

    // Hazard detection, accept decision and next-state logic
    always_comb begin
        state_nxt   = state;
        raw_hazard  = 1'b0;
        stall       = 1'b0;
        accept      = 1'b0;
        illegal_req = 1'b0;

        if (state == EXEC || state == WB) begin
            raw_hazard = (read_regport_f1 && fs1 == pend_rd) ||
                         (read_regport_f2 && fs2 == pend_rd);
        end

        // No write-to-read bypass in the FP regfile, so WB still stalls on RAW
        if (!flush) begin
            stall = (fpu_en && dec.legal && state == EXEC) || raw_hazard;
        end

        accept      = fpu_en && dec.legal && !flush && !stall &&
                      (state == IDLE || state == WB);
        illegal_req = fpu_en && !dec.legal && !flush && !stall;

        unique case (state)
            IDLE: if (accept) state_nxt = EXEC;
            EXEC: if (cnt == '0) state_nxt = WB;
            WB:   state_nxt = accept ? EXEC : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register plus op/latency/destination capture on accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            pend_rd   <= '0;
            op_q      <= OP_ADD;
            start_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            start_q   <= accept;
            illegal_q <= illegal_req;
            if (accept) begin
                op_q    <= dec.op;
                pend_rd <= fd;
                cnt     <= cnt_init(dec.op);
            end else if (state == EXEC && cnt != '0) begin
                cnt <= cnt - 5'd1;
            end
        end
    end

    assign fpu_start   = start_q;
    assign fpu_op      = op_q;
    assign wb_enable_f = (state == WB);
    assign wb_rd_f     = pend_rd;
    assign illegal_op  = illegal_q;
    assign busy        = (state != IDLE);

endmodule
